joy_db15_tx: RTL

- Responder end of the DB15 serial joystick link: it models the external parallel-in/serial-out shift chain that the DB15 reader polls over JOY_LOAD/JOY_CLK/JOY_DATA.
- Used in loopback benches and in board-to-board builds where one FPGA presents two joystick words to another FPGA's DB15 reader.
- Samples two 16-bit joystick words on a load strobe and shifts them out serially, active-low, on the host's clock edges.

---
 rtl/joy_db15_tx.sv | 113 +++++++++++
 1 files changed

// File: rtl/joy_db15_tx.sv
// DB15 joystick responder: emulates the parallel-in/serial-out chain a DB15 reader polls.
// Two joystick words are captured while JOY_LOAD is low, then shifted out active-low on JOY_CLK rises.
module joy_db15_tx #(
  parameter int FRAME_BITS = 32,
  parameter int STABLE     = 2
) (
  input  logic        clk,
  input  logic        I_RESETn,
  input  logic [15:0] joystick1,
  input  logic [15:0] joystick2,
  input  logic        JOY_LOAD,
  input  logic        JOY_CLK,
  output logic        JOY_DATA,
  output logic        frame_done,
  output logic [5:0]  bit_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              sync_p0, sync_p1, flt;
  logic [2:0]              flt_cnt [2];
  logic                    clk_f_d;
  logic                    load_f, clk_f, clk_rise;
  logic                    do_load, do_shift, cnt_inc, last_shift;
  logic [FRAME_BITS-1:0]   sr;
  logic [31:0]             word_all;

  assign load_f   = flt[0];
  assign clk_f    = flt[1];
  assign clk_rise = clk_f & ~clk_f_d;
  assign word_all = {~joystick2, ~joystick1};
  assign JOY_DATA = sr[0];

  // Pin synchronizers and glitch filters; bit 0 carries JOY_LOAD, bit 1 carries JOY_CLK.
  always_ff @(posedge clk or negedge I_RESETn) begin
    if (!I_RESETn) begin
      sync_p0    <= 2'b01;
      sync_p1    <= 2'b01;
      flt        <= 2'b01;
      flt_cnt[0] <= '0;
      flt_cnt[1] <= '0;
      clk_f_d    <= 1'b0;
    end else begin
      sync_p0 <= {JOY_CLK, JOY_LOAD};
      sync_p1 <= sync_p0;
      clk_f_d <= clk_f;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == flt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] + 3'd1 == 3'(STABLE)) begin
          flt[i]     <= sync_p1[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge I_RESETn) begin
    if (!I_RESETn) state <= IDLE;
    else           state <= state_nxt;
  end

  // A low filtered load always wins, including over a coincident shift edge.
  always_comb begin
    state_nxt  = state;
    do_load    = 1'b0;
    do_shift   = 1'b0;
    cnt_inc    = 1'b0;
    last_shift = 1'b0;
    if (!load_f) begin
      state_nxt = LOAD;
      do_load   = 1'b1;
    end else begin
      case (state)
        LOAD:  state_nxt = SHIFT;
        SHIFT: begin
          if (clk_rise) begin
            do_shift = 1'b1;
            cnt_inc  = 1'b1;
            if (bit_cnt == 6'(FRAME_BITS - 1)) begin
              last_shift = 1'b1;
              state_nxt  = DONE;
            end
          end
        end
        DONE:    do_shift = clk_rise;
        default: ;
      endcase
    end
  end

  // Shift chain: ones fill from the top so an overclocked host reads released buttons.
  always_ff @(posedge clk or negedge I_RESETn) begin
    if (!I_RESETn) begin
      sr         <= '1;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_shift;
      if (do_load) begin
        sr      <= word_all[FRAME_BITS-1:0];
        bit_cnt <= '0;
      end else if (do_shift) begin
        sr <= {1'b1, sr[FRAME_BITS-1:1]};
        if (cnt_inc) bit_cnt <= bit_cnt + 6'd1;
      end
    end
  end

endmodule
